// File: rtl/bit_pack_buffer.sv
// Packs variable-length fragments LSB-first into OUT_WIDTH words with flush support.
// Optional BIT_PACK_STATS_EN adds word/bit handshake counters.
module bit_pack_buffer #(
  parameter int OUT_WIDTH = 128,
  parameter int IN_WIDTH  = 128,
  parameter int AMT_WIDTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [AMT_WIDTH-1:0]            i_push_amount,
  input  logic [IN_WIDTH-1:0]             i_word,
  input  logic                            i_flush,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [OUT_WIDTH-1:0]            o_word,
  output logic                            o_last,
  output logic [$clog2(OUT_WIDTH):0]      o_bits,
  output logic                            o_flush_done,
  output logic [$clog2(2*OUT_WIDTH):0]    o_fill
`ifdef BIT_PACK_STATS_EN
  ,
  output logic [31:0]                     o_word_count,
  output logic [31:0]                     o_bit_count
`endif
);

  localparam int ACC_W  = 2 * OUT_WIDTH;
  localparam int FILL_W = $clog2(2 * OUT_WIDTH) + 1;
  localparam int BITS_W = $clog2(OUT_WIDTH) + 1;
  localparam logic [FILL_W-1:0]    OUT_F = FILL_W'(OUT_WIDTH);
  localparam logic [AMT_WIDTH-1:0] IN_A  = AMT_WIDTH'(IN_WIDTH);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                flush_done_q, flush_done_d;

  logic [AMT_WIDTH-1:0] amt_clamped;
  logic [FILL_W-1:0]    amt;
  logic [IN_WIDTH-1:0]  frag;
  logic [FILL_W-1:0]    out_fill;
  logic [FILL_W-1:0]    fill_base;
  logic [ACC_W-1:0]     acc_base;
  logic                 push;
  logic                 pop;

  assign amt_clamped = (i_push_amount > IN_A) ? IN_A : i_push_amount;
  assign amt         = FILL_W'(amt_clamped);

  // Bits at or above the amount are dropped so the accumulator stays zero above fill.
  for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_mask
    assign frag[gi] = i_word[gi] & (amt > FILL_W'(gi));
  end

  assign out_fill     = (fill_q > OUT_F) ? OUT_F : fill_q;
  assign o_ready      = (state_q == ST_RUN) && (fill_q <= OUT_F);
  assign o_valid      = (fill_q >= OUT_F) || ((state_q == ST_FLUSH) && (fill_q != '0));
  assign o_word       = acc_q[OUT_WIDTH-1:0];
  assign o_bits       = BITS_W'(out_fill);
  assign o_last       = (state_q == ST_FLUSH) && (fill_q <= OUT_F) && o_valid;
  assign o_flush_done = flush_done_q;
  assign o_fill       = fill_q;

  assign push = i_valid && o_ready;
  assign pop  = o_valid && i_ready;

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    acc_base     = acc_q;
    fill_base    = fill_q;
    if (pop) begin
      acc_base  = acc_q >> OUT_WIDTH;
      fill_base = fill_q - out_fill;
    end
    // A same-cycle push lands directly above whatever survives the pop.
    acc_d  = acc_base;
    fill_d = fill_base;
    if (push) begin
      acc_d  = acc_base | (ACC_W'(frag) << fill_base);
      fill_d = fill_base + amt;
    end
    case (state_q)
      ST_RUN: begin
        if (i_flush) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if ((fill_q == '0) || (pop && o_last)) begin
          state_d      = ST_RUN;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      flush_done_q <= flush_done_d;
    end
  end

`ifdef BIT_PACK_STATS_EN
  logic [31:0] word_count_q, word_count_d;
  logic [31:0] bit_count_q, bit_count_d;

  always_comb begin
    word_count_d = word_count_q + 32'(pop);
    bit_count_d  = bit_count_q + (push ? 32'(amt) : 32'd0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      word_count_q <= '0;
      bit_count_q  <= '0;
    end else begin
      word_count_q <= word_count_d;
      bit_count_q  <= bit_count_d;
    end
  end

  assign o_word_count = word_count_q;
  assign o_bit_count  = bit_count_q;
`endif

endmodule

// File: tb/tb_bit_pack_buffer.sv
// Scoreboard bench for bit_pack_buffer: a bit-queue reference model predicts every
// emitted word; a forked monitor compares whenever a word is handed off.
module tb_bit_pack_buffer;

  logic         i_clk;
  logic         i_reset;
  logic         i_valid;
  logic         o_ready;
  logic [7:0]   i_push_amount;
  logic [127:0] i_word;
  logic         i_flush;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_word;
  logic         o_last;
  logic [7:0]   o_bits;
  logic         o_flush_done;
  logic [8:0]   o_fill;

  bit_pack_buffer #(.OUT_WIDTH(128), .IN_WIDTH(128), .AMT_WIDTH(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_push_amount(i_push_amount), .i_word(i_word), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_word(o_word), .o_last(o_last),
    .o_bits(o_bits), .o_flush_done(o_flush_done), .o_fill(o_fill)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [127:0] w;
    int           bits;
    bit           stream_end;
  } exp_t;

  bit   bq[$];
  exp_t expq[$];
  int   checks;
  int   passes;
  int   pushed_bits;
  int   popped_bits;
  int   flush_issued;
  int   done_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void model_push(input int a, input logic [127:0] word);
    exp_t e;
    for (int i = 0; i < a; i++) bq.push_back(word[i]);
    while (bq.size() >= 128) begin
      e.w = '0;
      for (int i = 0; i < 128; i++) e.w[i] = bq.pop_front();
      e.bits = 128;
      e.stream_end = 1'b0;
      expq.push_back(e);
    end
  endfunction

  function automatic void model_flush();
    exp_t e;
    if (bq.size() > 0) begin
      e.w = '0;
      e.bits = bq.size();
      for (int i = 0; i < e.bits; i++) e.w[i] = bq.pop_front();
      e.stream_end = 1'b1;
      expq.push_back(e);
    end else if (expq.size() > 0) begin
      e = expq.pop_back();
      e.stream_end = 1'b1;
      expq.push_back(e);
    end
  endfunction

  task automatic monitor();
    exp_t e;
    bit   active;
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        expq.delete();
        popped_bits = 0;
        done_cnt = 0;
      end else begin
        if (o_flush_done) begin
          done_cnt++;
          check("drain_on_done", 128'(expq.size()), 128'(0));
        end
        active = (flush_issued > done_cnt);
        check("fill", 128'(o_fill), 128'(pushed_bits - popped_bits));
        check("ready", 128'(o_ready), 128'(!active && ((pushed_bits - popped_bits) <= 128)));
        if (o_valid) begin
          if (expq.size() == 0) begin
            check("spurious_valid", 128'(o_valid), 128'(0));
          end else if (i_ready) begin
            e = expq.pop_front();
            check("word", o_word, e.w);
            check("bits", 128'(o_bits), 128'(e.bits));
            check("last", 128'(o_last), 128'(e.stream_end && active));
            popped_bits += e.bits;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_push(input int amt_raw, input logic [127:0] word, input bit flush, input bit rnd);
    bit done = 1'b0;
    int a = (amt_raw > 128) ? 128 : amt_raw;
    i_valid = 1'b1;
    i_push_amount = 8'(amt_raw);
    i_word = word;
    i_flush = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (rnd) i_ready = ($urandom_range(0, 3) != 0);
      @(negedge i_clk);
      if (o_ready) begin
        i_flush = flush;
        model_push(a, word);
        if (flush) model_flush();
        done = 1'b1;
      end
      @(posedge i_clk);
      if (done) begin
        pushed_bits += a;
        if (flush) flush_issued++;
      end
      #1;
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    check("push_accept", 128'(done), 128'(1));
  endtask

  task automatic do_flush();
    @(negedge i_clk);
    i_flush = 1'b1;
    model_flush();
    @(posedge i_clk);
    flush_issued++;
    #1;
    i_flush = 1'b0;
  endtask

  task automatic wait_done(input bit rnd);
    for (int c = 0; c < 800 && done_cnt < flush_issued; c++) begin
      if (rnd) i_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    check("flush_done_seen", 128'(done_cnt >= flush_issued), 128'(1));
  endtask

  logic [127:0] w1, w2, exp_bp, mask;

  initial begin
    checks = 0; passes = 0;
    pushed_bits = 0; popped_bits = 0; flush_issued = 0; done_cnt = 0;
    i_reset = 1'b0; i_valid = 1'b1; i_flush = 1'b1; i_ready = 1'b0;
    i_push_amount = 8'd16; i_word = '1;
    fork
      monitor();
      begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
      end
    join_none

    // Reset with push and flush requested
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    @(negedge i_clk);
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_fill", 128'(o_fill), 128'(0));
    check("rst_ready", 128'(o_ready), 128'(1));
    check("rst_done", 128'(o_flush_done), 128'(0));
    step();

    // Steady packing: eight 16-bit fragments make one word
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) do_push(16, 128'h1111, 1'b0, 1'b0);
    @(negedge i_clk);
    check("steady_valid", 128'(o_valid), 128'(1));
    check("steady_word", o_word, 128'h1111_1111_1111_1111_1111_1111_1111_1111);
    check("steady_bits", 128'(o_bits), 128'(128));
    @(posedge i_clk);
    @(negedge i_clk);
    check("steady_fill", 128'(o_fill), 128'(0));
    step();

    // Backpressure and wrap across the word boundary
    i_ready = 1'b0;
    w1 = {$urandom, $urandom, $urandom, $urandom};
    w1[15:0] = 16'hABCD;
    w2 = {$urandom, $urandom, $urandom, $urandom};
    mask = (128'b1 << 100) - 128'b1;
    exp_bp = (w1 & mask) | (w2 << 100);
    do_push(100, w1, 1'b0, 1'b0);
    do_push(100, w2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("bp_fill", 128'(o_fill), 128'(200));
      check("bp_ready", 128'(o_ready), 128'(0));
      check("bp_word_stable", o_word, exp_bp);
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    mask = (128'b1 << 72) - 128'b1;
    check("wrap_fill", 128'(o_fill), 128'(72));
    check("wrap_ready", 128'(o_ready), 128'(1));
    check("wrap_word", o_word, (w2 >> 28) & mask);
    step();
    do_flush();
    wait_done(1'b0);

    // Flush tail together with the last fragment
    i_ready = 1'b0;
    w1 = {$urandom, $urandom, $urandom, $urandom};
    w1[39:0] = 40'hAB_CDEF_ABCD;
    do_push(40, w1, 1'b1, 1'b0);
    @(negedge i_clk);
    check("tail_valid", 128'(o_valid), 128'(1));
    check("tail_last", 128'(o_last), 128'(1));
    check("tail_bits", 128'(o_bits), 128'(40));
    check("tail_word", o_word, 128'h0000_0000_0000_0000_0000_00AB_CDEF_ABCD);
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk);
    @(negedge i_clk);
    check("tail_done_pulse", 128'(o_flush_done), 128'(1));
    check("tail_fill", 128'(o_fill), 128'(0));
    @(negedge i_clk);
    check("tail_done_clear", 128'(o_flush_done), 128'(0));
    step();

    // Clamp, zero-length push, and empty flush
    i_ready = 1'b0;
    do_push(200, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    @(negedge i_clk);
    check("clamp_fill", 128'(o_fill), 128'(128));
    step();
    do_push(0, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    @(negedge i_clk);
    check("zero_fill", 128'(o_fill), 128'(128));
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    do_flush();
    @(negedge i_clk);
    check("empty_flush_valid", 128'(o_valid), 128'(0));
    check("empty_flush_ready", 128'(o_ready), 128'(0));
    @(negedge i_clk);
    check("empty_flush_done", 128'(o_flush_done), 128'(1));
    check("empty_flush_valid2", 128'(o_valid), 128'(0));
    step();

    // Randomized fragments, flushes and backpressure
    for (int n = 0; n < 250; n++) begin
      bit fl;
      if ($urandom_range(0, 4) == 0) begin
        i_ready = ($urandom_range(0, 3) != 0);
        step();
      end
      fl = ($urandom_range(0, 15) == 0);
      do_push($urandom_range(0, 140), {$urandom, $urandom, $urandom, $urandom}, fl, 1'b1);
      if (fl) wait_done(1'b1);
    end
    i_ready = 1'b1;
    do_flush();
    wait_done(1'b0);
    step();
    check("final_drain", 128'(expq.size() + bq.size()), 128'(0));

    // Reset while a flushed word is waiting
    i_ready = 1'b0;
    do_push(100, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
    @(negedge i_clk);
    check("pre_rst_valid", 128'(o_valid), 128'(1));
    check("pre_rst_last", 128'(o_last), 128'(1));
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    i_ready = 1'b1;
    bq.delete();
    pushed_bits = 0;
    flush_issued = 0;
    step();
    i_reset = 1'b1;
    @(negedge i_clk);
    check("mid_rst_valid", 128'(o_valid), 128'(0));
    check("mid_rst_last", 128'(o_last), 128'(0));
    check("mid_rst_fill", 128'(o_fill), 128'(0));
    check("mid_rst_ready", 128'(o_ready), 128'(1));
    repeat (2) @(negedge i_clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
